// File: rtl/alu_serial_frame_rx.sv
// Serial frame receiver: NUM_OPERANDS*DATA_BYTES DATA packets plus one CMD packet, CRC4-checked.
// Optional FRAME_TIMEOUT_EN aborts a partial frame after TIMEOUT_CYCLES idle cycles between packets.
module alu_serial_frame_rx #(
    parameter int DATA_BYTES     = 4,
    parameter int NUM_OPERANDS   = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 sin,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [NUM_OPERANDS*DATA_BYTES*8-1:0] data_out,
    output logic [2:0]                           op_out,
    output logic                                 err_out,
    output logic [2:0]                           err_flags
);

    localparam int W    = NUM_OPERANDS * DATA_BYTES * 8;
    localparam int NPKT = NUM_OPERANDS * DATA_BYTES;
    localparam int PW   = $clog2(NPKT + 1);
    localparam logic [PW-1:0] NPKT_C = PW'(NPKT);

    typedef enum logic [2:0] {S_IDLE, S_FLAG, S_BITS, S_STOP, S_RECOVER} state_t;

    state_t          r_state, w_next;
    logic [2:0]      r_bit_cnt;
    logic [PW-1:0]   r_pkt_cnt;
    logic            r_flag;
    logic [7:0]      r_payload;
    logic [W-1:0]    r_shadow;
    logic [3:0]      r_crc;
    logic [3:0]      r_rec_cnt;
    logic            r_out_valid;
    logic [W-1:0]    r_data_out;
    logic [2:0]      r_op_out;
    logic            r_err_out;
    logic [2:0]      r_err_flags;

    logic            w_done, w_good, w_timeout, w_crc_en;
    logic [2:0]      w_flags;
    logic [3:0]      w_crc_next;
    logic            w_unused_cfg;

    assign w_unused_cfg = (TIMEOUT_CYCLES != 0);

`ifdef FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_idle_cnt;

    assign w_timeout = (r_state == S_IDLE) && sin && (r_pkt_cnt != '0) &&
                       (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_idle_cnt <= '0;
        else if ((r_state == S_IDLE) && sin && (r_pkt_cnt != '0) && !w_timeout)
            r_idle_cnt <= r_idle_cnt + TW'(1);
        else
            r_idle_cnt <= '0;
    end
`else
    assign w_timeout = 1'b0;
`endif

    // CMD packets feed only the op bits (payload bits 6:4) into the CRC
    assign w_crc_en   = (r_state == S_BITS) &&
                        (!r_flag || (r_bit_cnt >= 3'd1 && r_bit_cnt <= 3'd3));
    assign w_crc_next = {r_crc[2:0], 1'b0} ^ ((r_crc[3] ^ sin) ? 4'b0011 : 4'b0000);

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_done  = 1'b0;
        w_good  = 1'b0;
        w_flags = '0;
        case (r_state)
            S_IDLE: begin
                if (w_timeout) begin
                    w_done  = 1'b1;
                    w_flags = 3'b100;
                end else if (!sin) begin
                    w_next = S_FLAG;
                end
            end
            S_FLAG: w_next = S_BITS;
            S_BITS: if (r_bit_cnt == 3'd7) w_next = S_STOP;
            S_STOP: begin
                w_next = S_IDLE;
                if (!sin || (!r_flag && r_pkt_cnt == NPKT_C) ||
                    (r_flag && (r_pkt_cnt != NPKT_C || r_payload[7]))) begin
                    w_done  = 1'b1;
                    w_flags = 3'b100;
                    w_next  = S_RECOVER;
                end else if (r_flag && (r_crc != r_payload[3:0])) begin
                    w_done  = 1'b1;
                    w_flags = 3'b010;
                    w_next  = S_RECOVER;
                end else if (r_flag) begin
                    w_done = 1'b1;
                    w_good = 1'b1;
                end
            end
            S_RECOVER: if (sin && r_rec_cnt == 4'd10) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_pkt_cnt <= '0;
            r_flag    <= 1'b0;
            r_payload <= '0;
            r_shadow  <= '0;
            r_crc     <= '0;
            r_rec_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_bit_cnt <= '0;
                    if (w_timeout) begin
                        r_pkt_cnt <= '0;
                        r_crc     <= '0;
                    end
                end
                S_FLAG: r_flag <= sin;
                S_BITS: begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    r_payload <= {r_payload[6:0], sin};
                    if (!r_flag) r_shadow <= {r_shadow[W-2:0], sin};
                    if (w_crc_en) r_crc <= w_crc_next;
                end
                S_STOP: begin
                    r_rec_cnt <= '0;
                    if (w_done) begin
                        r_pkt_cnt <= '0;
                        r_crc     <= '0;
                    end else begin
                        r_pkt_cnt <= r_pkt_cnt + PW'(1);
                    end
                end
                S_RECOVER: r_rec_cnt <= sin ? r_rec_cnt + 4'd1 : 4'd0;
                default: ;
            endcase
        end
    end

    // Overrun keeps the held result and only marks it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
            r_op_out    <= '0;
            r_err_out   <= 1'b0;
            r_err_flags <= '0;
        end else if (w_done) begin
            if (r_out_valid && !out_ready) begin
                r_err_flags[0] <= 1'b1;
            end else begin
                r_out_valid <= 1'b1;
                r_data_out  <= w_good ? r_shadow : '0;
                r_op_out    <= w_good ? r_payload[6:4] : 3'b000;
                r_err_out   <= !w_good;
                r_err_flags <= w_flags;
            end
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign data_out  = r_data_out;
    assign op_out    = r_op_out;
    assign err_out   = r_err_out;
    assign err_flags = r_err_flags;

endmodule

// File: tb/tb_alu_serial_frame_rx.sv
// Bench for alu_serial_frame_rx: default 2x32-bit instance plus a 1x8-bit instance.
module tb_alu_serial_frame_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, sin0, sin1, rdy0, rdy1;
    logic        val0, val1, err0, err1;
    logic [63:0] dout0;
    logic [7:0]  dout1;
    logic [2:0]  op0, op1, fl0, fl1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] data;
        logic [2:0]  op;
        logic        err;
        logic [2:0]  flags;
    } exp_t;

    typedef struct {
        logic [63:0] data;
        logic [2:0]  op;
        logic        auto_crc;
        logic [3:0]  crc;
        logic        bit7;
        int          gap;
        logic        exp_err;
        logic [2:0]  exp_flags;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    vec_t vt[7];

    alu_serial_frame_rx #(.DATA_BYTES(4), .NUM_OPERANDS(2), .TIMEOUT_CYCLES(64)) dut0 (
        .clk(clk), .rst_n(rst_n), .sin(sin0), .out_valid(val0), .out_ready(rdy0),
        .data_out(dout0), .op_out(op0), .err_out(err0), .err_flags(fl0)
    );

    alu_serial_frame_rx #(.DATA_BYTES(1), .NUM_OPERANDS(1), .TIMEOUT_CYCLES(64)) dut1 (
        .clk(clk), .rst_n(rst_n), .sin(sin1), .out_valid(val1), .out_ready(rdy1),
        .data_out(dout1), .op_out(op1), .err_out(err1), .err_flags(fl1)
    );

    function automatic logic [3:0] crc_model(input logic [63:0] d, input int nbytes, input logic [2:0] op);
        logic [3:0] c;
        logic       fb;
        c = 4'b0000;
        for (int i = nbytes * 8 - 1; i >= 0; i--) begin
            fb = c[3] ^ d[i];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
        end
        for (int i = 2; i >= 0; i--) begin
            fb = c[3] ^ op[i];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
        end
        return c;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic cmp_res(input string name, input exp_t e, input logic [63:0] d,
                           input logic [2:0] op, input logic err, input logic [2:0] fl);
        checks++;
        if ({d, op, err, fl} !== {e.data, e.op, e.err, e.flags}) begin
            errors++;
            $display("FAIL %s: got data=%h op=%0d err=%0b flags=%b expected data=%h op=%0d err=%0b flags=%b",
                     name, d, op, err, fl, e.data, e.op, e.err, e.flags);
        end
    endtask

    // One cycle: score any result accepted at the coming edge, then move to the next falling edge
    task automatic cyc();
        if (val0 && rdy0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result0: got data=%h flags=%b expected none", dout0, fl0);
            end else begin
                cmp_res("result0", q0.pop_front(), dout0, op0, err0, fl0);
            end
        end
        if (val1 && rdy1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result1: got data=%h flags=%b expected none", dout1, fl1);
            end else begin
                cmp_res("result1", q1.pop_front(), {56'b0, dout1}, op1, err1, fl1);
            end
        end
        @(negedge clk);
    endtask

    task automatic put_bit(input int which, input logic b);
        if (which == 0) sin0 = b; else sin1 = b;
        cyc();
    endtask

    task automatic idle(input int which, input int n);
        repeat (n) put_bit(which, 1'b1);
    endtask

    task automatic send_pkt(input int which, input logic flag, input logic [7:0] pay, input logic stopb);
        put_bit(which, 1'b0);
        put_bit(which, flag);
        for (int i = 7; i >= 0; i--) put_bit(which, pay[i]);
        put_bit(which, stopb);
    endtask

    task automatic send_frame(input int which, input logic [63:0] d, input int nbytes, input logic [2:0] op,
                              input logic [3:0] crc, input logic bit7, input int gap);
        for (int k = nbytes - 1; k >= 0; k--) begin
            send_pkt(which, 1'b0, d[k*8 +: 8], 1'b1);
            idle(which, gap);
        end
        send_pkt(which, 1'b1, {bit7, op, crc}, 1'b1);
    endtask

    function automatic exp_t good(input logic [63:0] d, input logic [2:0] op);
        exp_t e;
        e.data = d; e.op = op; e.err = 1'b0; e.flags = 3'b000;
        return e;
    endfunction

    function automatic exp_t bad(input logic [2:0] fl);
        exp_t e;
        e.data = '0; e.op = 3'd0; e.err = 1'b1; e.flags = fl;
        return e;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t       e;
        logic [3:0] crc;
        logic [63:0] a_data;

        vt[0] = '{64'h0, 3'd0, 1'b0, 4'b0000, 1'b0, 0, 1'b0, 3'b000};
        vt[1] = '{64'h1, 3'd0, 1'b0, 4'b1011, 1'b0, 0, 1'b0, 3'b000};
        vt[2] = '{64'h1, 3'd1, 1'b0, 4'b1000, 1'b0, 0, 1'b0, 3'b000};
        vt[3] = '{64'h1, 3'd0, 1'b0, 4'b0000, 1'b0, 0, 1'b1, 3'b010};
        vt[4] = '{64'hDEADBEEF_12345678, 3'd5, 1'b1, 4'b0000, 1'b0, 3, 1'b0, 3'b000};
        vt[5] = '{64'hA5C3_0FF0_8001_7E24, 3'd7, 1'b1, 4'b0000, 1'b0, 1, 1'b0, 3'b000};
        vt[6] = '{64'h0123_4567_89AB_CDEF, 3'd3, 1'b1, 4'b0000, 1'b1, 0, 1'b1, 3'b100};

        rst_n = 1'b0; sin0 = 1'b1; sin1 = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1;
        @(negedge clk);
        repeat (3) cyc();
        chk("reset_valid", {62'b0, val1, val0}, 64'h0);
        chk("reset_data", dout0 | {56'b0, dout1}, 64'h0);
        chk("reset_misc", {52'b0, op0, op1, err0, err1, fl0, fl1}, 64'h0);
        rst_n = 1'b1;
        cyc();

        for (int i = 0; i < 7; i++) begin
            crc = vt[i].auto_crc ? crc_model(vt[i].data, 8, vt[i].op) : vt[i].crc;
            q0.push_back(vt[i].exp_err ? bad(vt[i].exp_flags) : good(vt[i].data, vt[i].op));
            send_frame(0, vt[i].data, 8, vt[i].op, crc, vt[i].bit7, vt[i].gap);
            chk($sformatf("latency_vec%0d", i), {63'b0, val0}, 64'h1);
            idle(0, 11);
        end

        // CMD arrives after only 5 DATA packets
        for (int k = 0; k < 5; k++) send_pkt(0, 1'b0, 8'h11 * k[7:0], 1'b1);
        chk("early_cmd_no_result", {63'b0, val0}, 64'h0);
        q0.push_back(bad(3'b100));
        send_pkt(0, 1'b1, 8'h20, 1'b1);
        chk("early_cmd_valid", {63'b0, val0}, 64'h1);
        idle(0, 11);

        // Stop bit 0 in the third packet
        send_pkt(0, 1'b0, 8'h31, 1'b1);
        send_pkt(0, 1'b0, 8'h32, 1'b1);
        chk("badstop_no_result", {63'b0, val0}, 64'h0);
        q0.push_back(bad(3'b100));
        send_pkt(0, 1'b0, 8'h33, 1'b0);
        chk("badstop_valid", {63'b0, val0}, 64'h1);
        idle(0, 11);

        // Ninth DATA packet where CMD is expected
        for (int k = 0; k < 8; k++) send_pkt(0, 1'b0, 8'h40 + k[7:0], 1'b1);
        q0.push_back(bad(3'b100));
        send_pkt(0, 1'b0, 8'h48, 1'b1);
        chk("extra_data_valid", {63'b0, val0}, 64'h1);
        idle(0, 11);

        // Overrun: second good frame while the first is still held
        rdy0 = 1'b0;
        a_data = 64'hCAFE_F00D_0BAD_BEEF;
        e = good(a_data, 3'd2);
        e.flags = 3'b001;
        q0.push_back(e);
        send_frame(0, a_data, 8, 3'd2, crc_model(a_data, 8, 3'd2), 1'b0, 0);
        idle(0, 3);
        chk("held_valid", {63'b0, val0}, 64'h1);
        send_frame(0, 64'h1111_2222_3333_4444, 8, 3'd6, crc_model(64'h1111_2222_3333_4444, 8, 3'd6), 1'b0, 0);
        idle(0, 2);
        chk("held_data", dout0, a_data);
        rdy0 = 1'b1;
        cyc();
        chk("valid_fall", {63'b0, val0}, 64'h0);
        idle(0, 4);

        // Reset with a result held and a partial frame in flight
        rdy0 = 1'b0;
        send_frame(0, 64'h5555_AAAA_5555_AAAA, 8, 3'd1, crc_model(64'h5555_AAAA_5555_AAAA, 8, 3'd1), 1'b0, 0);
        chk("pre_reset_valid", {63'b0, val0}, 64'h1);
        for (int k = 0; k < 3; k++) send_pkt(0, 1'b0, 8'h77, 1'b1);
        put_bit(0, 1'b0);
        put_bit(0, 1'b0);
        put_bit(0, 1'b1);
        rst_n = 1'b0;
        sin0 = 1'b1;
        cyc();
        cyc();
        chk("midframe_reset_out", {dout0[59:0], val0, err0, fl0[1:0]} | {57'b0, op0, fl0}, 64'h0);
        rst_n = 1'b1;
        rdy0 = 1'b1;
        idle(0, 2);
        a_data = 64'h0F1E_2D3C_4B5A_6978;
        q0.push_back(good(a_data, 3'd4));
        send_frame(0, a_data, 8, 3'd4, crc_model(a_data, 8, 3'd4), 1'b0, 2);
        idle(0, 11);

        // 1x8-bit instance
        q1.push_back(good(64'h01, 3'd0));
        send_frame(1, 64'h01, 1, 3'd0, 4'b1011, 1'b0, 0);
        chk("narrow_latency", {63'b0, val1}, 64'h1);
        idle(1, 11);

`ifdef FRAME_TIMEOUT_EN
        send_pkt(1, 1'b0, 8'h5A, 1'b1);
        idle(1, 63);
        q1.push_back(good(64'h5A, 3'd6));
        send_pkt(1, 1'b1, {1'b0, 3'd6, crc_model(64'h5A, 1, 3'd6)}, 1'b1);
        chk("gap63_valid", {63'b0, val1}, 64'h1);
        idle(1, 11);
        send_pkt(1, 1'b0, 8'hC3, 1'b1);
        idle(1, 63);
        chk("no_early_timeout", {63'b0, val1}, 64'h0);
        q1.push_back(bad(3'b100));
        idle(1, 1);
        chk("timeout_valid", {63'b0, val1}, 64'h1);
        idle(1, 2);
        q1.push_back(good(64'h7E, 3'd4));
        send_frame(1, 64'h7E, 1, 3'd4, crc_model(64'h7E, 1, 3'd4), 1'b0, 0);
        idle(1, 11);
`else
        send_pkt(1, 1'b0, 8'h5A, 1'b1);
        idle(1, 100);
        chk("partial_waits", {63'b0, val1}, 64'h0);
        q1.push_back(good(64'h5A, 3'd6));
        send_pkt(1, 1'b1, {1'b0, 3'd6, crc_model(64'h5A, 1, 3'd6)}, 1'b1);
        chk("late_cmd_valid", {63'b0, val1}, 64'h1);
        idle(1, 11);
`endif

        idle(0, 5);
        chk("queue0_drained", 64'(q0.size()), 64'h0);
        chk("queue1_drained", 64'(q1.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
